// File: rtl/multicycle_datapath.sv
// multicycle_datapath: RV32I-subset multicycle datapath.
// Regfile, ALU, immediates, PC; control decodes IR externally.
`timescale 1ns/1ps
module multicycle_datapath #(
  parameter int          XLEN       = 32,
  parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            iReq,
  input  logic            iAck,
  input  logic [31:0]     iData,
  output logic [31:0]     IR,
  input  logic            ALUSrc,
  input  logic            RegWrite,
  input  logic            MemToReg,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      BrType,
  input  logic [3:0]      ALUCtrl,
  output logic            dReq,
  output logic            dWE,
  output logic [XLEN-1:0] dAddress,
  output logic [XLEN-1:0] dWriteData,
  input  logic            dAck,
  input  logic [XLEN-1:0] dReadData,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] WriteBackData,
  output logic            Zero,
  output logic            retire
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t state, state_n;

  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] alu_q, mdr_q, link_q;
  logic            redir_q;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  logic [XLEN-1:0] op2, alu_res;
  logic [XLEN-1:0] pc4, br_tgt, jr_sum;
  logic [SW-1:0]   shamt;
  logic [4:0]      rd;
  logic            take, is_jump, is_mem, is_wb;

  assign rd = IR[11:7];

  assign imm_i = {{(XLEN-12){IR[31]}}, IR[31:20]};
  assign imm_s = {{(XLEN-12){IR[31]}},
                  IR[31:25], IR[11:7]};
  assign imm_b = {{(XLEN-13){IR[31]}}, IR[31],
                  IR[7], IR[30:25], IR[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){IR[31]}}, IR[31],
                  IR[19:12], IR[20], IR[30:21], 1'b0};

  assign op2   = !ALUSrc  ? b_q   :
                 MemWrite ? imm_s : imm_i;
  assign shamt = imm_i[SW-1:0];

  assign is_jump = (BrType == 3'b101)
                || (BrType == 3'b110);
  assign is_mem  = MemRead | MemWrite;
  assign is_wb   = RegWrite | is_jump;

  assign pc4    = PC + XLEN'(4);
  assign br_tgt = PC + ((BrType == 3'b101) ? imm_j : imm_b);
  assign jr_sum = a_q + imm_i;

  assign dAddress      = alu_q;
  assign dWriteData    = b_q;
  assign WriteBackData = is_jump  ? link_q :
                         MemToReg ? mdr_q  : alu_q;

  // ALU: shifts take their amount from the immediate only
  always_comb begin
    alu_res = '0;
    unique case (ALUCtrl)
      4'b0000: alu_res = a_q & op2;
      4'b0001: alu_res = a_q | op2;
      4'b0010: alu_res = a_q + op2;
      4'b0011: alu_res = a_q ^ op2;
      4'b0100: alu_res = {{(XLEN-1){1'b0}}, a_q < op2};
      4'b0110: alu_res = a_q - op2;
      4'b0111: alu_res = {{(XLEN-1){1'b0}},
                          $signed(a_q) < $signed(op2)};
      4'b1000: alu_res = a_q << shamt;
      4'b1001: alu_res = a_q >> shamt;
      4'b1010: alu_res = $unsigned($signed(a_q) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // branch comparator, independent of the ALU result
  always_comb begin
    take = 1'b0;
    unique case (BrType)
      3'b001:  take = (a_q == b_q);
      3'b010:  take = (a_q != b_q);
      3'b011:  take = ($signed(a_q) < $signed(b_q));
      3'b100:  take = ($signed(a_q) >= $signed(b_q));
      3'b101,
      3'b110:  take = 1'b1;
      default: take = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  // next state and handshake/retire outputs
  always_comb begin
    state_n = state;
    iReq    = 1'b0;
    dReq    = 1'b0;
    dWE     = 1'b0;
    retire  = 1'b0;
    unique case (state)
      S_FETCH: begin
        iReq = 1'b1;
        if (iAck) state_n = S_DECODE;
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        if (is_mem)     state_n = S_MEM;
        else if (is_wb) state_n = S_WB;
        else begin
          state_n = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        dReq = 1'b1;
        dWE  = MemWrite;
        if (dAck) begin
          if (MemWrite) begin
            state_n = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // datapath registers, regfile and PC update
  always_ff @(posedge clk) begin
    if (rst) begin
      PC      <= XLEN'(INITIAL_PC);
      IR      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      link_q  <= '0;
      redir_q <= 1'b0;
      Zero    <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (iAck) IR <= iData;
        end
        S_DECODE: begin
          a_q     <= rf[IR[19:15]];
          b_q     <= rf[IR[24:20]];
          redir_q <= 1'b0;
        end
        S_EXEC: begin
          alu_q  <= alu_res;
          Zero   <= (alu_res == '0);
          link_q <= pc4;
          if (take) begin
            redir_q <= 1'b1;
            if (BrType == 3'b110)
              PC <= {jr_sum[XLEN-1:1], 1'b0};
            else
              PC <= br_tgt;
          end else if (!is_mem && !is_wb) begin
            PC <= pc4;
          end
        end
        S_MEM: begin
          if (dAck) begin
            if (MemWrite) PC <= pc4;
            else          mdr_q <= dReadData;
          end
        end
        S_WB: begin
          if (RegWrite && rd != 5'd0)
            rf[rd] <= WriteBackData;
          if (!redir_q) PC <= pc4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: ISA-level reference model,
// bench-side control decode, randomized wait states.
`timescale 1ns/1ps
module tb_multicycle_datapath;

  logic        clk, rst;
  logic        iReq, iAck;
  logic [31:0] iData, IR;
  logic        ALUSrc, RegWrite, MemToReg;
  logic        MemRead, MemWrite;
  logic [2:0]  BrType;
  logic [3:0]  ALUCtrl;
  logic        dReq, dWE, dAck;
  logic [31:0] dAddress, dWriteData, dReadData;
  logic [31:0] PC, WriteBackData;
  logic        Zero, retire;

  multicycle_datapath dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iAck(iAck), .iData(iData), .IR(IR),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .BrType(BrType),
    .ALUCtrl(ALUCtrl),
    .dReq(dReq), .dWE(dWE), .dAddress(dAddress),
    .dWriteData(dWriteData), .dAck(dAck),
    .dReadData(dReadData),
    .PC(PC), .WriteBackData(WriteBackData),
    .Zero(Zero), .retire(retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: got timeout want handshake", nm);
  endtask

  // control unit stand-in
  function automatic logic [3:0] alu_of(
      input logic [2:0] f3, input logic f7b,
      input logic isimm);
    case (f3)
      3'd0:    return (f7b && !isimm) ? 4'b0110 : 4'b0010;
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b0100;
      3'd4:    return 4'b0011;
      3'd5:    return f7b ? 4'b1010 : 4'b1001;
      3'd6:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  always_comb begin
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    BrType   = 3'b000;
    ALUCtrl  = 4'b0010;
    case (IR[6:0])
      7'h13: begin
        ALUSrc = 1'b1; RegWrite = 1'b1;
        ALUCtrl = alu_of(IR[14:12], IR[30], 1'b1);
      end
      7'h33: begin
        RegWrite = 1'b1;
        ALUCtrl = alu_of(IR[14:12], IR[30], 1'b0);
      end
      7'h03: begin
        ALUSrc = 1'b1; RegWrite = 1'b1;
        MemToReg = 1'b1; MemRead = 1'b1;
      end
      7'h23: begin
        ALUSrc = 1'b1; MemWrite = 1'b1;
      end
      7'h63: begin
        ALUCtrl = 4'b0110;
        case (IR[14:12])
          3'd0:    BrType = 3'b001;
          3'd1:    BrType = 3'b010;
          3'd4:    BrType = 3'b011;
          3'd5:    BrType = 3'b100;
          default: BrType = 3'b000;
        endcase
      end
      7'h6f: begin
        RegWrite = 1'b1; BrType = 3'b101;
      end
      7'h67: begin
        RegWrite = 1'b1; BrType = 3'b110;
        ALUSrc = 1'b1;
      end
      default: ;
    endcase
  end

  // instruction encoders
  function automatic logic [31:0] enc_i(
      input logic [31:0] im, input logic [4:0] r1,
      input logic [2:0] f3, input logic [4:0] rd,
      input logic [6:0] op);
    return {im[11:0], r1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(
      input logic [6:0] f7, input logic [4:0] r2,
      input logic [4:0] r1, input logic [2:0] f3,
      input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(
      input logic [31:0] im, input logic [4:0] r2,
      input logic [4:0] r1);
    return {im[11:5], r2, r1, 3'd2, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(
      input logic [31:0] im, input logic [4:0] r2,
      input logic [4:0] r1, input logic [2:0] f3);
    return {im[12], im[10:5], r2, r1, f3,
            im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(
      input logic [31:0] im, input logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12],
            rd, 7'h6f};
  endfunction

  // architectural reference model
  typedef struct {
    logic [31:0] nxt, wbd, addr, wdata, ld;
    logic        wbv, mem, we, zchk;
    int          lat;
  } exp_t;

  logic [31:0] regs [32];
  logic [31:0] mpc;
  logic [31:0] mem [logic [31:0]];
  exp_t        exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) regs[i] = '0;
    mpc = 32'h00400000;
  endtask

  task automatic model(input logic [31:0] ins,
                       input int iw, input int dw,
                       output exp_t e);
    logic [31:0] a, b, ii, si, bi, ji, val;
    logic [4:0]  rd, sh;
    logic [2:0]  f3;
    logic        tk;
    rd  = ins[11:7];
    f3  = ins[14:12];
    sh  = ins[24:20];
    a   = regs[ins[19:15]];
    b   = regs[ins[24:20]];
    ii  = {{20{ins[31]}}, ins[31:20]};
    si  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bi  = {{19{ins[31]}}, ins[31], ins[7],
           ins[30:25], ins[11:8], 1'b0};
    ji  = {{11{ins[31]}}, ins[31], ins[19:12],
           ins[20], ins[30:21], 1'b0};
    val = '0;
    tk  = 1'b0;
    e   = '{default: '0};
    e.lat = 4 + iw;
    e.nxt = mpc + 32'd4;
    e.wdata = b;
    case (ins[6:0])
      7'h13: begin
        e.wbv = 1'b1; e.zchk = 1'b1;
        case (f3)
          3'd0: val = a + ii;
          3'd1: val = a << sh;
          3'd2: val = {31'b0, $signed(a) < $signed(ii)};
          3'd3: val = {31'b0, a < ii};
          3'd4: val = a ^ ii;
          3'd5: if (ins[30]) val = $signed(a) >>> sh;
                else         val = a >> sh;
          3'd6: val = a | ii;
          default: val = a & ii;
        endcase
      end
      7'h33: begin
        e.wbv = 1'b1; e.zchk = 1'b1;
        case (f3)
          3'd0: if (ins[30]) val = a - b;
                else         val = a + b;
          3'd2: val = {31'b0, $signed(a) < $signed(b)};
          3'd3: val = {31'b0, a < b};
          3'd4: val = a ^ b;
          3'd6: val = a | b;
          default: val = a & b;
        endcase
      end
      7'h03: begin
        e.addr = a + ii;
        e.mem = 1'b1; e.wbv = 1'b1;
        val = mem.exists(e.addr) ? mem[e.addr] : $urandom;
        e.ld = val;
        e.lat = 5 + iw + dw;
      end
      7'h23: begin
        e.addr = a + si;
        e.mem = 1'b1; e.we = 1'b1;
        mem[e.addr] = b;
        e.lat = 4 + iw + dw;
      end
      7'h63: begin
        e.lat = 3 + iw;
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          default: tk = ($signed(a) >= $signed(b));
        endcase
        if (tk) e.nxt = mpc + bi;
      end
      7'h6f: begin
        e.wbv = 1'b1; val = mpc + 32'd4;
        e.nxt = mpc + ji;
      end
      default: begin
        e.wbv = 1'b1; val = mpc + 32'd4;
        e.nxt = (a + ii) & ~32'd1;
      end
    endcase
    e.wbd = val;
    if (e.wbv && rd != 5'd0) regs[rd] = val;
    mpc = e.nxt;
  endtask

  // compare process: every cycle out of reset
  int          lat_cnt = 0;
  logic        pc_chk  = 1'b0;
  logic [31:0] pc_exp;
  logic [31:0] last_wbd, last_addr;
  int          last_lat;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lat_cnt = 0;
      pc_chk  = 1'b0;
    end else begin
      lat_cnt++;
      chk("req_excl", {63'b0, iReq & dReq}, 64'd0);
      if (pc_chk) begin
        chk("next_pc", PC, pc_exp);
        pc_chk = 1'b0;
      end
      if (dReq && exp_q.size() > 0) begin
        last_addr = dAddress;
        chk("d_addr", dAddress, exp_q[0].addr);
        chk("d_we", dWE, exp_q[0].we);
        if (exp_q[0].we)
          chk("d_wdata", dWriteData, exp_q[0].wdata);
      end
      if (retire) begin
        if (exp_q.size() == 0) begin
          tmo("retire_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("latency", 64'(lat_cnt), 64'(e.lat));
          if (e.wbv) chk("wb_data", WriteBackData, e.wbd);
          if (e.zchk)
            chk("zero", Zero, e.wbd == 32'd0);
          pc_exp   = e.nxt;
          pc_chk   = 1'b1;
          last_wbd = WriteBackData;
          last_lat = lat_cnt;
        end
        lat_cnt = 0;
      end
    end
  end

  // driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!iReq && n < 40) begin step(); n++; end
    if (!iReq) tmo("fetch_wait");
  endtask

  task automatic issue(input logic [31:0] ins,
                       input int iw, input int dw);
    exp_t e;
    int   n;
    wait_fetch();
    repeat (iw) begin
      iAck = 1'b0;
      dAck = 1'($urandom_range(0, 1));
      dReadData = $urandom;
      step();
    end
    model(ins, iw, dw, e);
    exp_q.push_back(e);
    dAck  = 1'b0;
    iAck  = 1'b1;
    iData = ins;
    step();
    iAck  = 1'b0;
    iData = $urandom;
    if (e.mem) begin
      n = 0;
      while (!dReq && n < 10) begin step(); n++; end
      if (!dReq) tmo("dreq_wait");
      repeat (dw) begin
        dAck = 1'b0;
        iAck = 1'($urandom_range(0, 1));
        step();
      end
      iAck = 1'b0;
      dAck = 1'b1;
      dReadData = e.ld;
      step();
      dAck = 1'b0;
      dReadData = $urandom;
    end
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0]  rd, r1, r2;
    logic [31:0] im;
    logic [2:0]  rf3 [6];
    logic [2:0]  if3 [5];
    logic [2:0]  bf3 [4];
    logic [2:0]  f3;
    logic [6:0]  f7;
    rf3 = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    if3 = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5};
    rd = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    im = $urandom;
    case ($urandom_range(0, 8))
      0: return enc_i(im, r1, 3'd0, rd, 7'h13);
      1: begin
        f3 = rf3[$urandom_range(0, 5)];
        f7 = (f3 == 3'd0 && $urandom_range(0, 1) == 1)
             ? 7'h20 : 7'h00;
        return enc_r(f7, r2, r1, f3, rd);
      end
      2: begin
        f3 = ($urandom_range(0, 1) == 1) ? 3'd5 : 3'd1;
        f7 = (f3 == 3'd5 && $urandom_range(0, 1) == 1)
             ? 7'h20 : 7'h00;
        return enc_i({20'b0, f7, im[4:0]}, r1, f3, rd,
                     7'h13);
      end
      3: return enc_i(im, r1, if3[$urandom_range(0, 4)],
                      rd, 7'h13);
      4: return enc_i(im, r1, 3'd2, rd, 7'h03);
      5: return enc_s(im, r2, r1);
      6: return enc_b(im, r2, r1, bf3[$urandom_range(0, 3)]);
      7: return enc_j(im, rd);
      default: return enc_i(im, r1, 3'd0, rd, 7'h67);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;
    rst = 1'b1;
    iAck = 1'b0; dAck = 1'b0;
    iData = '0; dReadData = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", PC, 32'h00400000);
    chk("rst_ireq", iReq, 1'b1);
    chk("rst_dreq", dReq, 1'b0);
    chk("rst_ir", IR, 32'd0);
    chk("rst_retire", retire, 1'b0);
    rst = 1'b0;

    mem[32'h0] = 32'h00400103;
    issue(32'hFFD00293, 0, 0);
    wait_fetch();
    chk("addi_wbd", last_wbd, 32'hFFFFFFFD);
    chk("addi_lat", last_lat, 4);
    issue(enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13), 0, 0);
    issue(enc_i(-1, 5'd0, 3'd0, 5'd2, 7'h13), 1, 0);
    issue(enc_i(32'd0, 5'd0, 3'd0, 5'd0, 7'h13), 2, 0);
    issue(enc_b(32'd16, 5'd1, 5'd2, 3'd4), 0, 0);
    wait_fetch();
    chk("blt_pc", PC, 32'h00400020);
    chk("blt_lat", last_lat, 3);
    issue(enc_i(32'd0, 5'd0, 3'd2, 5'd6, 7'h03), 0, 0);
    issue(enc_i(32'd8, 5'd6, 3'd0, 5'd1, 7'h67), 0, 0);
    wait_fetch();
    chk("jalr_pc", PC, 32'h0040010A);
    chk("jalr_link", last_wbd, 32'h00400028);
    issue(enc_s(32'd4, 5'd2, 5'd1), 0, 3);
    wait_fetch();
    chk("sw_lat", last_lat, 7);
    chk("sw_addr", last_addr, 32'h0040002C);
    issue(enc_i(32'd4, 5'd1, 3'd2, 5'd3, 7'h03), 0, 3);
    wait_fetch();
    chk("lw_lat", last_lat, 8);
    chk("lw_wbd", last_wbd, 32'hFFFFFFFF);
    issue(enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd7), 0, 0);
    wait_fetch();
    chk("x3_read", last_wbd, 32'hFFFFFFFF);

    // reset while a store waits in MEM
    model(enc_s(32'd0, 5'd2, 5'd0), 0, 0, e);
    exp_q.push_back(e);
    iAck = 1'b1;
    iData = enc_s(32'd0, 5'd2, 5'd0);
    step();
    iAck = 1'b0;
    n = 0;
    while (!dReq && n < 10) begin step(); n++; end
    if (!dReq) tmo("mem_reach");
    step();
    rst = 1'b1;
    dAck = 1'b1;
    iAck = 1'b1;
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    dAck = 1'b0;
    iAck = 1'b0;
    model_reset();
    chk("mrst_dreq", dReq, 1'b0);
    chk("mrst_pc", PC, 32'h00400000);
    chk("mrst_ireq", iReq, 1'b1);

    for (int k = 0; k < 400; k++) begin
      issue(rand_ins(),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
            $urandom_range(0, 3));
    end
    wait_fetch();
    step();
    chk("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
